cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic_if.sv | 30 +++
 rtl/cond_logic.sv | 76 +++++++
 tb/tb_cond_logic.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cond_logic_if.sv
// Decode-to-execute control bundle for the condition unit: decoder requests
// and ALU flags in, gated write strobes, flags and perf counters out.
interface cond_logic_if;
   logic        en;
   logic [3:0]  cond;
   logic [3:0]  alu_flags;
   logic [1:0]  flag_w;
   logic        pc_s;
   logic        reg_w;
   logic        mem_w;
   logic        no_write;
   logic        cnt_clr;
   logic        pc_src;
   logic        reg_write;
   logic        mem_write;
   logic        cond_ex;
   logic [3:0]  flags;
   logic [31:0] retired_cnt;
   logic [31:0] skipped_cnt;

   modport master (
      output en, cond, alu_flags, flag_w, pc_s, reg_w, mem_w, no_write, cnt_clr,
      input  pc_src, reg_write, mem_write, cond_ex, flags, retired_cnt, skipped_cnt
   );

   modport slave (
      input  en, cond, alu_flags, flag_w, pc_s, reg_w, mem_w, no_write, cnt_clr,
      output pc_src, reg_write, mem_write, cond_ex, flags, retired_cnt, skipped_cnt
   );
endinterface

// File: rtl/cond_logic.sv
// ARM-style conditional execution unit: evaluates the condition field
// against the registered NZCV flags, gates the decoder write requests,
// updates the flags and keeps retired/skipped instruction counters.
module cond_logic (
   input logic         clk,
   input logic         reset_n,
   cond_logic_if.slave bus
);
   logic [3:0]  r_flags;
   logic [31:0] r_retired;
   logic [31:0] r_skipped;
   logic        w_n, w_z, w_c, w_v;
   logic        w_cond_ex;
   logic        w_exec;

   assign {w_n, w_z, w_c, w_v} = r_flags;

   // Condition decode; looks only at the registered flags, so a flag write
   // becomes visible one cycle after its edge.
   always_comb begin
      w_cond_ex = 1'b0;
      case (bus.cond)
         4'b0000: w_cond_ex = w_z;
         4'b0001: w_cond_ex = ~w_z;
         4'b0010: w_cond_ex = w_c;
         4'b0011: w_cond_ex = ~w_c;
         4'b0100: w_cond_ex = w_n;
         4'b0101: w_cond_ex = ~w_n;
         4'b0110: w_cond_ex = w_v;
         4'b0111: w_cond_ex = ~w_v;
         4'b1000: w_cond_ex = ~w_z & w_c;
         4'b1001: w_cond_ex = w_z | ~w_c;
         4'b1010: w_cond_ex = (w_n == w_v);
         4'b1011: w_cond_ex = (w_n != w_v);
         4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
         4'b1101: w_cond_ex = w_z | (w_n != w_v);
         4'b1110: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   assign w_exec = bus.en & w_cond_ex;

   // Flag register: each half written independently, only by an executed instruction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_flags <= 4'b0000;
      end else if (w_exec) begin
         if (bus.flag_w[1]) r_flags[3:2] <= bus.alu_flags[3:2];
         if (bus.flag_w[0]) r_flags[1:0] <= bus.alu_flags[1:0];
      end
   end

   // Perf counters: clear wins; otherwise exactly one counter steps per enabled cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_retired <= 32'd0;
         r_skipped <= 32'd0;
      end else if (bus.cnt_clr) begin
         r_retired <= 32'd0;
         r_skipped <= 32'd0;
      end else if (w_exec) begin
         r_retired <= r_retired + 32'd1;
      end else if (bus.en) begin
         r_skipped <= r_skipped + 32'd1;
      end
   end

   assign bus.cond_ex     = w_cond_ex;
   assign bus.pc_src      = w_exec & bus.pc_s;
   assign bus.mem_write   = w_exec & bus.mem_w;
   assign bus.reg_write   = w_exec & bus.reg_w & ~bus.no_write;
   assign bus.flags       = r_flags;
   assign bus.retired_cnt = r_retired;
   assign bus.skipped_cnt = r_skipped;
endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: expected outputs are queued as each
// cycle is driven and popped against the DUT when it is sampled.
module tb_cond_logic;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   cond_logic_if bus();

   cond_logic dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [3:0]  m_flags = 4'b0;
   logic [31:0] m_ret = 32'd0;
   logic [31:0] m_skp = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic pop(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", obs, 32'hDEAD_BEEF);
      end else begin
         e = sb.pop_front();
         chk(e.tag, obs, e.v);
      end
   endtask

   // Reference: odd codes invert the even predicate; 111x is AL/never.
   function automatic logic pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, b;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cf;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cf && !z;
         3'd5: b = !(n ^ v);
         3'd6: b = !(n ^ v) && !z;
         default: b = 1'b1;
      endcase
      if (c == 4'b1111) return 1'b0;
      if (c == 4'b1110) return 1'b1;
      return c[0] ? !b : b;
   endfunction

   task automatic push_regs(input string pfx);
      push({pfx, "_flags"}, {28'd0, m_flags});
      push({pfx, "_ret"}, m_ret);
      push({pfx, "_skp"}, m_skp);
   endtask

   task automatic pop_regs();
      pop({28'd0, bus.flags});
      pop(bus.retired_cnt);
      pop(bus.skipped_cnt);
   endtask

   // One instruction cycle, entered and left at a falling edge.
   task automatic cyc(input string tag, input logic e, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw, input logic ps,
                      input logic rw, input logic mw, input logic nw, input logic clr);
      logic p;
      bus.en = e; bus.cond = c; bus.alu_flags = af; bus.flag_w = fw;
      bus.pc_s = ps; bus.reg_w = rw; bus.mem_w = mw; bus.no_write = nw; bus.cnt_clr = clr;
      #1;
      p = pass(c, m_flags);
      push({tag, "_cex"}, {31'd0, p});
      push({tag, "_pc"},  {31'd0, e && p && ps});
      push({tag, "_rw"},  {31'd0, e && p && rw && !nw});
      push({tag, "_mw"},  {31'd0, e && p && mw});
      pop({31'd0, bus.cond_ex});
      pop({31'd0, bus.pc_src});
      pop({31'd0, bus.reg_write});
      pop({31'd0, bus.mem_write});
      @(posedge clk);
      if (reset_n) begin
         if (e && p) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
         end
         if (clr) begin
            m_ret = 32'd0; m_skp = 32'd0;
         end else if (e && p) m_ret = m_ret + 32'd1;
         else if (e) m_skp = m_skp + 32'd1;
      end
      #1;
      push_regs(tag);
      pop_regs();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en = 1'b0; bus.cond = 4'b0001; bus.alu_flags = 4'b0; bus.flag_w = 2'b0;
      bus.pc_s = 1'b0; bus.reg_w = 1'b0; bus.mem_w = 1'b0; bus.no_write = 1'b0; bus.cnt_clr = 1'b0;
      #2;
      push_regs("rst");
      pop_regs();
      push("rst_ne_cex", 32'd1);
      pop({31'd0, bus.cond_ex});
      @(negedge clk);
      // In reset the unit still decodes with zeroed flags but must not count.
      cyc("rst_hold", 1'b1, 4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b1;

      cyc("eq_fail", 1'b1, 4'b0000, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("set_z",   1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // EQ passes on the old Z=1 while it writes Z=0; next EQ must fail.
      cyc("eq_same", 1'b1, 4'b0000, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("eq_next", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("nz_only", 1'b1, 4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("cmp",     1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("rw_mw",   1'b1, 4'b0100, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("pl_fail", 1'b1, 4'b0101, 4'b0111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("stall",   1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("nv",      1'b1, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      m_ret = 32'hFFFF_FFFF;
      cyc("wrap",    1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("pre_clr", 1'b1, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("clr",     1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] rc, ra;
         logic [1:0] rf;
         logic [5:0] rb;
         rc = 4'($urandom_range(0, 15));
         ra = 4'($urandom_range(0, 15));
         rf = 2'($urandom_range(0, 3));
         rb = 6'($urandom);
         cyc("rnd", rb[0] | rb[1], rc, ra, rf, rb[2], rb[3], rb[4], rb[5],
             ($urandom_range(0, 15) == 0));
      end

      cyc("all1",    1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("cnt",     1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Asynchronous reset between edges clears state without a clock.
      #2;
      reset_n = 1'b0;
      m_flags = 4'b0; m_ret = 32'd0; m_skp = 32'd0;
      #1;
      push_regs("async");
      pop_regs();
      @(negedge clk);
      cyc("in_rst",  1'b1, 4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b1;
      cyc("post_rst", 1'b1, 4'b0001, 4'b1010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("post_stall", 1'b0, 4'b1110, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

      if (sb.size() != 0) chk("sb_left", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
